// File: rtl/wordle_pkg.sv
// Shared constants, FSM state type and cell addressing for the Wordle board.
// The renderer imports this package too, so cell_base() must stay in step with it.
package wordle_pkg;
    localparam int ROWS   = 6;
    localparam int COLS   = 5;
    localparam int CELL_W = 7;
    localparam int LTR_W  = 5;
    localparam int DISP_W = ROWS * COLS * CELL_W;

    localparam logic [1:0] GRAY     = 2'd0;
    localparam logic [1:0] GREEN    = 2'd1;
    localparam logic [1:0] YELLOW   = 2'd2;
    localparam logic [1:0] UNSCORED = 2'd3;

    localparam logic [CELL_W-1:0] CELL_BLANK = {UNSCORED, 5'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCORE_G,
        S_SCORE_Y,
        S_FINISH,
        S_OVER
    } state_t;

    function automatic logic [7:0] cell_base(input logic [2:0] row, input logic [2:0] col);
        return 8'(row) * 8'd35 + 8'(col) * 8'd7;
    endfunction
endpackage

// File: rtl/wordle_board_row_scorer.sv
// Scores one five-letter guess against the answer with Wordle duplicate-letter rules.
// Greens are found in one step, then yellows are resolved one letter per cycle.
module row_scorer
    import wordle_pkg::*;
(
    input  logic                    dclk,
    input  logic                    clr,
    input  logic                    abort_i,
    input  logic                    start_i,
    input  logic [COLS*LTR_W-1:0]   guess_i,
    input  logic [COLS*LTR_W-1:0]   answer_i,
    output logic [2*COLS-1:0]       colours_o,
    output logic                    all_green_o,
    output logic                    done_o
);
    state_t           state_q;
    logic [LTR_W-1:0] guess_q [COLS];
    logic [LTR_W-1:0] ans_q   [COLS];
    logic [1:0]       colour_q [COLS];
    logic [COLS-1:0]  green_q;
    logic [COLS-1:0]  used_q;
    logic [2:0]       k_q;
    logic             done_q;

    logic [LTR_W-1:0] guess_w [COLS];
    logic [LTR_W-1:0] ans_w   [COLS];
    logic [COLS-1:0]  match_w;
    logic             hit_w;
    logic [2:0]       hit_j_w;

    for (genvar gc = 0; gc < COLS; gc++) begin : g_unpack
        assign guess_w[gc]              = guess_i[gc*LTR_W +: LTR_W];
        assign ans_w[gc]                = answer_i[gc*LTR_W +: LTR_W];
        assign match_w[gc]              = (guess_w[gc] == ans_w[gc]);
        assign colours_o[2*gc +: 2]     = colour_q[gc];
    end

    // Searching from the top down leaves the lowest free matching answer slot selected.
    always_comb begin
        hit_w   = 1'b0;
        hit_j_w = '0;
        for (int j = COLS - 1; j >= 0; j--) begin
            if (!used_q[j] && (ans_q[j] == guess_q[k_q])) begin
                hit_w   = 1'b1;
                hit_j_w = 3'(j);
            end
        end
    end

    // The green pass runs on the start edge itself, keeping the whole job to seven cycles.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            green_q <= '0;
            used_q  <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                guess_q[c]  <= '0;
                ans_q[c]    <= '0;
                colour_q[c] <= UNSCORED;
            end
        end else if (abort_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        for (int c = 0; c < COLS; c++) begin
                            guess_q[c] <= guess_w[c];
                            ans_q[c]   <= ans_w[c];
                        end
                        green_q <= match_w;
                        used_q  <= match_w;
                        k_q     <= '0;
                        state_q <= S_SCORE_Y;
                    end
                end
                S_SCORE_Y: begin
                    if (green_q[k_q]) begin
                        colour_q[k_q] <= GREEN;
                    end else if (hit_w) begin
                        colour_q[k_q]   <= YELLOW;
                        used_q[hit_j_w] <= 1'b1;
                    end else begin
                        colour_q[k_q] <= GRAY;
                    end
                    if (k_q == 3'(COLS - 1)) begin
                        state_q <= S_FINISH;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign all_green_o = &green_q;
    assign done_o      = done_q;
endmodule

// File: rtl/wordle_board.sv
// Wordle game state: builds the 6x5 guess grid from key strobes, scores guesses and
// drives the packed display vector plus win/lose status for the VGA renderer.
module wordle_board
    import wordle_pkg::*;
(
    input  logic                    dclk,
    input  logic                    clr,
    input  logic                    new_game_i,
    input  logic                    key_valid_i,
    input  logic [LTR_W-1:0]        key_code_i,
    input  logic                    key_del_i,
    input  logic                    key_enter_i,
    input  logic [COLS*LTR_W-1:0]   answer_i,
    output logic [DISP_W-1:0]       display_o,
    output logic [2:0]              cur_row_o,
    output logic [2:0]              cur_col_o,
    output logic                    busy_o,
    output logic                    won_o,
    output logic                    lost_o
);
    localparam logic [2:0] COL_FULL = 3'(COLS);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    state_t             state_q;
    logic [DISP_W-1:0]  grid_q;
    logic [2:0]         row_q;
    logic [2:0]         col_q;
    logic               busy_q;
    logic               won_q;
    logic               lost_q;
    logic               valid_q;
    logic               del_q;
    logic               enter_q;
    logic [LTR_W-1:0]   code_q;

    logic [COLS*LTR_W-1:0] guess_w;
    logic [DISP_W-1:0]     scored_w;
    logic [2*COLS-1:0]     colours_w;
    logic                  all_green_w;
    logic                  done_w;
    logic                  start_w;
    logic                  letter_ok_w;

    assign start_w     = (state_q == S_IDLE) && enter_q && (col_q == COL_FULL);
    assign letter_ok_w = (code_q != 5'd0) && (code_q <= 5'd26);

    // scored_w is the grid with the active row's colours replaced, committed in one write.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int B = int'(cell_base(3'(gr), 3'(gc)));
            assign scored_w[B +: CELL_W] = {(row_q == 3'(gr)) ? colours_w[2*gc +: 2]
                                                              : grid_q[B+LTR_W +: 2],
                                            grid_q[B +: LTR_W]};
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_guess
        assign guess_w[gc*LTR_W +: LTR_W] = grid_q[cell_base(row_q, 3'(gc)) +: LTR_W];
    end

    row_scorer u_scorer (
        .dclk        (dclk),
        .clr         (clr),
        .abort_i     (new_game_i),
        .start_i     (start_w),
        .guess_i     (guess_w),
        .answer_i    (answer_i),
        .colours_o   (colours_w),
        .all_green_o (all_green_w),
        .done_o      (done_w)
    );

    // Key strobes are registered first and acted on one edge later.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            grid_q  <= {(ROWS*COLS){CELL_BLANK}};
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
            valid_q <= 1'b0;
            del_q   <= 1'b0;
            enter_q <= 1'b0;
            code_q  <= '0;
        end else if (new_game_i) begin
            state_q <= S_IDLE;
            grid_q  <= {(ROWS*COLS){CELL_BLANK}};
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
            valid_q <= 1'b0;
            del_q   <= 1'b0;
            enter_q <= 1'b0;
            code_q  <= '0;
        end else begin
            valid_q <= key_valid_i;
            del_q   <= key_del_i;
            enter_q <= key_enter_i;
            code_q  <= key_code_i;
            case (state_q)
                S_IDLE: begin
                    if (enter_q) begin
                        if (col_q == COL_FULL) begin
                            state_q <= S_SCORE_G;
                            busy_q  <= 1'b1;
                        end
                    end else if (del_q) begin
                        if (col_q != 3'd0) begin
                            col_q <= col_q - 3'd1;
                            grid_q[cell_base(row_q, col_q - 3'd1) +: CELL_W] <= CELL_BLANK;
                        end
                    end else if (valid_q && letter_ok_w && (col_q != COL_FULL)) begin
                        grid_q[cell_base(row_q, col_q) +: CELL_W] <= {UNSCORED, code_q};
                        col_q <= col_q + 3'd1;
                    end
                end
                // The scorer sequences its own phases; here we wait for its done strobe.
                S_SCORE_G: begin
                    if (done_w) begin
                        grid_q <= scored_w;
                        busy_q <= 1'b0;
                        if (all_green_w) begin
                            won_q   <= 1'b1;
                            state_q <= S_OVER;
                        end else if (row_q == LAST_ROW) begin
                            lost_q  <= 1'b1;
                            state_q <= S_OVER;
                        end else begin
                            row_q   <= row_q + 3'd1;
                            col_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign display_o = grid_q;
    assign cur_row_o = row_q;
    assign cur_col_o = col_q;
    assign busy_o    = busy_q;
    assign won_o     = won_q;
    assign lost_o    = lost_q;
endmodule

// File: tb/tb_wordle_board.sv
// Scoreboard bench for wordle_board: stimulus pushes timed expectations, a monitor
// compares them against the DUT on the falling clock edge.
module tb_wordle_board;
    import wordle_pkg::*;

    localparam int K_LETTER       = 0;
    localparam int K_DEL          = 1;
    localparam int K_ENTER        = 2;
    localparam int K_LETTER_ENTER = 3;
    localparam int K_NEWGAME      = 4;

    logic         dclk = 1'b0;
    logic         clr = 1'b1;
    logic         newGame = 1'b0;
    logic         keyValid = 1'b0;
    logic [4:0]   keyCode = '0;
    logic         keyDel = 1'b0;
    logic         keyEnter = 1'b0;
    logic [24:0]  answer = '0;
    logic [209:0] dispO;
    logic [2:0]   rowO;
    logic [2:0]   colO;
    logic         busyO;
    logic         wonO;
    logic         lostO;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int           due;
        string        name;
        logic [209:0] disp;
        logic [2:0]   row;
        logic [2:0]   col;
        logic         busy;
        logic         won;
        logic         lost;
    } exp_t;

    exp_t sbq[$];

    logic [209:0] mDisp;
    logic [2:0]   mRow;
    logic [2:0]   mCol;
    logic         mWon;
    logic         mLost;
    logic         mOver;

    wordle_board dut (
        .dclk        (dclk),
        .clr         (clr),
        .new_game_i  (newGame),
        .key_valid_i (keyValid),
        .key_code_i  (keyCode),
        .key_del_i   (keyDel),
        .key_enter_i (keyEnter),
        .answer_i    (answer),
        .display_o   (dispO),
        .cur_row_o   (rowO),
        .cur_col_o   (colO),
        .busy_o      (busyO),
        .won_o       (wonO),
        .lost_o      (lostO)
    );

    always #20 dclk = ~dclk;

    always @(posedge dclk) cyc <= cyc + 1;

    function automatic logic [24:0] mkWord(input logic [4:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    function automatic logic [9:0] mkCol(input logic [1:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic resetModel();
        mDisp = {30{7'h60}};
        mRow  = 3'd0;
        mCol  = 3'd0;
        mWon  = 1'b0;
        mLost = 1'b0;
        mOver = 1'b0;
    endtask

    task automatic pushExp(input string nm, input int due, input logic busyV);
        exp_t e;
        e.due  = due;
        e.name = nm;
        e.disp = mDisp;
        e.row  = mRow;
        e.col  = mCol;
        e.busy = busyV;
        e.won  = mWon;
        e.lost = mLost;
        sbq.push_back(e);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge dclk);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (e.due != cyc || dispO !== e.disp || rowO !== e.row || colO !== e.col ||
            busyO !== e.busy || wonO !== e.won || lostO !== e.lost) begin
            mismatched++;
            $display("[TB] FAIL %s cyc=%0d due=%0d: got row=%0d col=%0d busy=%b won=%b lost=%b disp=%h ; want row=%0d col=%0d busy=%b won=%b lost=%b disp=%h",
                     e.name, cyc, e.due, rowO, colO, busyO, wonO, lostO, dispO,
                     e.row, e.col, e.busy, e.won, e.lost, e.disp);
        end
    endtask

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge dclk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            checkOutput(sbq.pop_front());
        end
    end

    task automatic applyStimulus(input int kind, input logic [4:0] code,
                                 input logic [9:0] expCol, input string nm);
        int n;
        int last;
        @(negedge dclk);
        n = cyc;
        case (kind)
            K_LETTER:       begin keyValid = 1'b1; keyCode = code; end
            K_DEL:          keyDel = 1'b1;
            K_ENTER:        keyEnter = 1'b1;
            K_LETTER_ENTER: begin keyValid = 1'b1; keyCode = code; keyEnter = 1'b1; end
            K_NEWGAME:      newGame = 1'b1;
            default:        ;
        endcase
        if (kind == K_NEWGAME) begin
            resetModel();
            pushExp(nm, n + 1, 1'b0);
            last = n + 1;
        end else if ((kind == K_ENTER || kind == K_LETTER_ENTER) && !mOver && mCol == 3'd5) begin
            pushExp({nm, "-pre"}, n + 1, 1'b0);
            for (int i = 2; i <= 8; i++) pushExp({nm, "-busy"}, n + i, 1'b1);
            for (int c = 0; c < 5; c++) mDisp[35*mRow + 7*c + 5 +: 2] = expCol[2*c +: 2];
            if (expCol == 10'b01_01_01_01_01) begin
                mWon = 1'b1;
                mOver = 1'b1;
            end else if (mRow == 3'd5) begin
                mLost = 1'b1;
                mOver = 1'b1;
            end else begin
                mRow = mRow + 3'd1;
                mCol = 3'd0;
            end
            pushExp({nm, "-done"}, n + 9, 1'b0);
            last = n + 9;
        end else begin
            if (!mOver && kind == K_DEL && mCol > 3'd0) begin
                mCol = mCol - 3'd1;
                mDisp[35*mRow + 7*mCol +: 7] = 7'h60;
            end else if (!mOver && kind == K_LETTER && mCol < 3'd5 && code >= 5'd1 && code <= 5'd26) begin
                mDisp[35*mRow + 7*mCol +: 7] = {2'b11, code};
                mCol = mCol + 3'd1;
            end
            pushExp(nm, n + 2, 1'b0);
            last = n + 2;
        end
        @(negedge dclk);
        keyValid = 1'b0;
        keyDel   = 1'b0;
        keyEnter = 1'b0;
        newGame  = 1'b0;
        keyCode  = '0;
        waitUntil(last + 1);
    endtask

    task automatic typeWord(input logic [24:0] w, input string nm);
        for (int i = 0; i < 5; i++) applyStimulus(K_LETTER, w[5*i +: 5], '0, nm);
    endtask

    task automatic pulseClr();
        int n;
        @(negedge dclk);
        n = cyc;
        #5 clr = 1'b1;
        #5 clr = 1'b0;
        resetModel();
        pushExp("clr-pulse", n + 1, 1'b0);
        waitUntil(n + 2);
    endtask

    // Enter, then new_game while the scorer is on its third yellow step.
    task automatic abortScoring();
        int n;
        @(negedge dclk);
        n = cyc;
        keyEnter = 1'b1;
        pushExp("abort-pre", n + 1, 1'b0);
        for (int i = 2; i <= 4; i++) pushExp("abort-busy", n + i, 1'b1);
        @(negedge dclk);
        keyEnter = 1'b0;
        waitUntil(n + 4);
        newGame = 1'b1;
        resetModel();
        pushExp("abort-reset", n + 5, 1'b0);
        pushExp("abort-never-coloured", n + 12, 1'b0);
        @(negedge dclk);
        newGame = 1'b0;
        waitUntil(n + 13);
    endtask

    initial begin
        int n;
        logic [24:0] crane;
        logic [24:0] abbey;
        crane = mkWord(5'd3, 5'd18, 5'd1, 5'd14, 5'd5);
        abbey = mkWord(5'd1, 5'd2, 5'd2, 5'd5, 5'd25);

        resetModel();
        repeat (3) @(negedge dclk);
        n = cyc;
        clr = 1'b0;
        pushExp("reset", n + 1, 1'b0);
        waitUntil(n + 2);

        answer = crane;
        typeWord(crane, "win-letter");
        applyStimulus(K_ENTER, '0, mkCol(2'd1, 2'd1, 2'd1, 2'd1, 2'd1), "win-enter");
        applyStimulus(K_LETTER, 5'd7, '0, "over-letter");
        applyStimulus(K_DEL, '0, '0, "over-del");
        applyStimulus(K_ENTER, '0, '0, "over-enter");

        pulseClr();
        answer = abbey;
        applyStimulus(K_DEL, '0, '0, "del-col0");
        applyStimulus(K_LETTER, 5'd2, '0, "dup-B");
        applyStimulus(K_LETTER, 5'd15, '0, "dup-O");
        applyStimulus(K_LETTER, 5'd27, '0, "bad-code-27");
        applyStimulus(K_LETTER, 5'd0, '0, "bad-code-0");
        applyStimulus(K_LETTER, 5'd24, '0, "dup-X");
        applyStimulus(K_DEL, '0, '0, "del-X");
        applyStimulus(K_LETTER, 5'd2, '0, "dup-B2");
        applyStimulus(K_LETTER, 5'd2, '0, "dup-B3");
        applyStimulus(K_ENTER, '0, '0, "enter-col4");
        applyStimulus(K_LETTER, 5'd25, '0, "dup-Y");
        applyStimulus(K_LETTER, 5'd26, '0, "sixth-letter");
        applyStimulus(K_LETTER_ENTER, 5'd7, mkCol(2'd2, 2'd0, 2'd1, 2'd0, 2'd1), "dup-enter+letter");

        applyStimulus(K_NEWGAME, '0, '0, "new-game");
        typeWord(mkWord(5'd26, 5'd26, 5'd26, 5'd26, 5'd26), "loss-r0");
        applyStimulus(K_ENTER, '0, mkCol(2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "loss-r0-enter");
        typeWord(mkWord(5'd25, 5'd5, 5'd2, 5'd2, 5'd1), "loss-r1");
        applyStimulus(K_ENTER, '0, mkCol(2'd2, 2'd2, 2'd1, 2'd2, 2'd2), "loss-r1-enter");
        typeWord(mkWord(5'd5, 5'd2, 5'd2, 5'd1, 5'd25), "loss-r2");
        applyStimulus(K_ENTER, '0, mkCol(2'd2, 2'd1, 2'd1, 2'd2, 2'd1), "loss-r2-enter");
        typeWord(mkWord(5'd1, 5'd1, 5'd1, 5'd1, 5'd1), "loss-r3");
        applyStimulus(K_ENTER, '0, mkCol(2'd1, 2'd0, 2'd0, 2'd0, 2'd0), "loss-r3-enter");
        typeWord(mkWord(5'd2, 5'd2, 5'd2, 5'd2, 5'd2), "loss-r4");
        applyStimulus(K_ENTER, '0, mkCol(2'd0, 2'd1, 2'd1, 2'd0, 2'd0), "loss-r4-enter");
        typeWord(mkWord(5'd26, 5'd26, 5'd26, 5'd26, 5'd26), "loss-r5");
        applyStimulus(K_ENTER, '0, mkCol(2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "loss-r5-enter");
        applyStimulus(K_LETTER, 5'd3, '0, "lost-letter");
        applyStimulus(K_DEL, '0, '0, "lost-del");

        applyStimulus(K_NEWGAME, '0, '0, "new-game-2");
        answer = crane;
        typeWord(crane, "abort-letter");
        abortScoring();
        applyStimulus(K_LETTER, 5'd1, '0, "after-abort-letter");

        waitUntil(cyc + 3);
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard-drain: %0d expectations left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        mismatched++;
        $display("[TB] FAIL watchdog: run did not end, pending=%0d want 0", sbq.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
